// File: rtl/store_pkg.sv
// Shared store-size encoding and the helpers that decode it.
package store_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_X = 2'd3
    } size_e;

    function automatic logic [31:0] size_to_len(input logic [1:0] size);
        case (size)
            SZ_B:    return 32'd1;
            SZ_H:    return 32'd2;
            SZ_W:    return 32'd4;
            default: return 32'd0;
        endcase
    endfunction

    // Illegal encoding, or an address not naturally aligned to the access size.
    function automatic logic size_illegal(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_B:    return 1'b0;
            SZ_H:    return addr_lo[0];
            SZ_W:    return addr_lo != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/store_buffer_if.sv
// Store input channel from the LSU and write channel towards the pmem write stage.
interface store_buffer_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_addr;
    logic [1:0]        in_size;
    logic [DATA_W-1:0] in_data;
    logic              out_en;
    logic [ADDR_W-1:0] out_addr;
    logic [31:0]       out_len;
    logic [DATA_W-1:0] out_data;

    modport master (
        output in_valid, in_addr, in_size, in_data,
        input  in_ready, out_en, out_addr, out_len, out_data
    );

    modport slave (
        input  in_valid, in_addr, in_size, in_data,
        output in_ready, out_en, out_addr, out_len, out_data
    );
endinterface

// File: rtl/store_fifo.sv
// Circular entry store with wrap-bit pointers; exposes the head plus a per-entry
// tag and valid flag so the owner can search all pending entries.
module store_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8,
    parameter int TW    = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int PW   = AW + 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [W-1:0]             wr_data,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output logic [PW-1:0]            count,
    output logic [W-1:0]             head,
    output logic [DEPTH-1:0][TW-1:0] tags,
    output logic [DEPTH-1:0]         valid
);

    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;
    logic          do_push;
    logic          do_pop;

    assign wr_idx  = wr_ptr_reg[AW-1:0];
    assign rd_idx  = rd_ptr_reg[AW-1:0];
    assign empty   = wr_ptr_reg == rd_ptr_reg;
    assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) && (wr_idx == rd_idx);
    assign count   = wr_ptr_reg - rd_ptr_reg;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_idx];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
        end
    end

    // Payload is never reset; the pointers alone decide what is valid.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_idx] <= wr_data;
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [AW-1:0] offset;
            assign offset     = AW'(gi) - rd_idx;
            assign valid[gi]  = {1'b0, offset} < count;
            assign tags[gi]   = mem[gi][W-1 -: TW];
        end
    endgenerate

endmodule

// File: rtl/store_buffer.sv
// Committed-store buffer: checks alignment, masks data, queues stores in order
// and drains one per cycle to the write stage; flags loads hitting a pending word.
module store_buffer
    import store_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    store_buffer_if.slave            bus,
    input  logic [ADDR_W-1:0]        ld_addr,
    output logic                     ld_hit,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     err
);

    localparam int EW = ADDR_W + 2 + DATA_W;

    logic                         full;
    logic                         empty;
    logic                         accept;
    logic                         illegal;
    logic                         enq;
    logic                         pop;
    logic                         err_reg;
    logic [DATA_W-1:0]            data_mask;
    logic [EW-1:0]                wr_entry;
    logic [EW-1:0]                head;
    logic [DEPTH-1:0][ADDR_W-1:0] tags;
    logic [DEPTH-1:0]             valid;
    logic [DEPTH-1:0]             hit_vec;
    logic [ADDR_W-1:0]            ld_word;
    logic [ADDR_W-1:0]            head_addr;
    logic [1:0]                   head_size;
    logic [DATA_W-1:0]            head_data;

    assign bus.in_ready = !full;
    assign accept       = bus.in_valid && !full;
    assign illegal      = size_illegal(bus.in_size, bus.in_addr[1:0]);
    assign enq          = accept && !illegal;
    assign pop          = !empty;

    generate
        for (genvar gi = 0; gi < DATA_W; gi++) begin : g_mask
            assign data_mask[gi] = (gi < 8)
                                || (gi < 16 && bus.in_size == SZ_H)
                                || (gi < 32 && bus.in_size == SZ_W);
        end
    endgenerate

    assign wr_entry = {bus.in_addr, bus.in_size, bus.in_data & data_mask};

    store_fifo #(
        .DEPTH (DEPTH),
        .W     (EW),
        .TW    (ADDR_W)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push    (enq),
        .wr_data (wr_entry),
        .pop     (pop),
        .full    (full),
        .empty   (empty),
        .count   (count),
        .head    (head),
        .tags    (tags),
        .valid   (valid)
    );

    assign head_addr    = head[EW-1 -: ADDR_W];
    assign head_size    = head[DATA_W +: 2];
    assign head_data    = head[DATA_W-1:0];
    assign bus.out_en   = !empty;
    assign bus.out_addr = head_addr;
    assign bus.out_len  = size_to_len(head_size);
    assign bus.out_data = head_data;

    // Word match ignores the byte offset on both sides; the popping head still counts.
    assign ld_word = ld_addr & ~ADDR_W'(3);
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
            assign hit_vec[gi] = valid[gi] && ((tags[gi] & ~ADDR_W'(3)) == ld_word);
        end
    endgenerate
    assign ld_hit = |hit_vec;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) err_reg <= 1'b0;
        else        err_reg <= accept && illegal;
    end
    assign err = err_reg;

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer with a write-order scoreboard.
module tb_store_buffer;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] len;
        logic [31:0] data;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] ld_addr;
    logic        ld_hit;
    logic [2:0]  count;
    logic        err;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    bit   hold_drain = 1'b0;

    store_buffer_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    store_buffer #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
        .clock   (clock),
        .reset   (reset),
        .bus     (bus.slave),
        .ld_addr (ld_addr),
        .ld_hit  (ld_hit),
        .count   (count),
        .err     (err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one store for one cycle; the expected write is queued only if legal.
    task automatic drive_store(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] data);
        exp_t e;
        logic legal;
        legal = (size == 2'd0) || (size == 2'd1 && addr[0] == 1'b0) || (size == 2'd2 && addr[1:0] == 2'b00);
        bus.in_valid = 1'b1;
        bus.in_addr  = addr;
        bus.in_size  = size;
        bus.in_data  = data;
        if (legal) begin
            e.addr = addr;
            e.len  = (size == 2'd0) ? 32'd1 : (size == 2'd1) ? 32'd2 : 32'd4;
            e.data = (size == 2'd0) ? (data & 32'h0000_00FF) :
                     (size == 2'd1) ? (data & 32'h0000_FFFF) : data;
            sb.push_back(e);
        end
    endtask

    task automatic send(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] data);
        drive_store(addr, size, data);
        @(negedge clock);
        bus.in_valid = 1'b0;
    endtask

    // Write monitor: every cycle with out_en (and draining enabled) pops one store.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (bus.out_en === 1'b1 && !hold_drain) begin
                tests++;
                assert (sb.size() != 0) else begin
                    fails++;
                    $error("FAIL unexpected_write: observed addr 0x%0h, expected no write", bus.out_addr);
                end
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    $display("[TB] write addr=0x%08h len=%0d data=0x%08h", bus.out_addr, bus.out_len, bus.out_data);
                    chk("out_addr", bus.out_addr, e.addr);
                    chk("out_len",  bus.out_len,  e.len);
                    chk("out_data", bus.out_data, e.data);
                end
            end
        end
    end

    logic [31:0] bad_addr [3];
    logic [1:0]  bad_size [3];

    initial begin
        bad_addr = '{32'h8000_0001, 32'h8000_0008, 32'h8000_0006};
        bad_size = '{2'd1, 2'd3, 2'd2};
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_addr  = '0;
        bus.in_size  = '0;
        bus.in_data  = '0;
        ld_addr      = 32'h8000_0004;
        #1 reset = 1'b0;
        repeat (2) @(negedge clock);
        chk("rst_count",    count, 0);
        chk("rst_out_en",   bus.out_en, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_err",      err, 0);
        chk("rst_ld_hit",   ld_hit, 0);
        reset = 1'b1;
        @(negedge clock);

        // Word store appears the cycle after acceptance, then drains.
        send(32'h8000_0004, 2'd2, 32'hDEAD_BEEF);
        chk("word_out_en", bus.out_en, 1);
        chk("word_count",  count, 1);
        chk("word_ld_hit", ld_hit, 1);
        @(negedge clock);
        chk("word_count_after", count, 0);
        chk("word_out_en_after", bus.out_en, 0);

        send(32'h8000_0003, 2'd0, 32'h1234_5678);
        @(negedge clock);
        send(32'h8000_0002, 2'd1, 32'hCAFE_BABE);
        @(negedge clock);

        // Illegal / misaligned stores: nothing queued, err for one cycle.
        for (int i = 0; i < 3; i++) begin
            send(bad_addr[i], bad_size[i], 32'hA5A5_0000 + i);
            chk("bad_err",    err, 1);
            chk("bad_count",  count, 0);
            chk("bad_out_en", bus.out_en, 0);
            @(negedge clock);
            chk("bad_err_clear", err, 0);
        end

        // Fill to DEPTH with draining held off, then one extra store.
        hold_drain = 1'b1;
        force dut.pop = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            send(32'h8000_0010 + 32'(i) * 32'h10, 2'd2, 32'h1111_0000 + i);
            chk("fill_count", count, i + 1);
        end
        chk("full_in_ready", bus.in_ready, 0);
        ld_addr = 32'h8000_0013;
        #1 chk("ld_hit_same_word", ld_hit, 1);
        ld_addr = 32'h8000_0014;
        #1 chk("ld_hit_next_word", ld_hit, 0);
        ld_addr = 32'h8000_0043;
        #1 chk("ld_hit_last_entry", ld_hit, 1);
        @(negedge clock);
        drive_store(32'h8000_0050, 2'd2, 32'h5555_5555);
        @(negedge clock);
        chk("held_count",    count, DEPTH);
        chk("held_in_ready", bus.in_ready, 0);
        @(posedge clock);
        #4;
        hold_drain = 1'b0;
        release dut.pop;
        @(negedge clock);
        chk("release_count", count, DEPTH);
        @(negedge clock);
        chk("after_pop_count",    count, DEPTH - 1);
        chk("after_pop_in_ready", bus.in_ready, 1);
        @(negedge clock);
        chk("enq_deq_count", count, DEPTH - 1);
        bus.in_valid = 1'b0;
        for (int i = 0; i < 20 && bus.out_en === 1'b1; i++) @(negedge clock);
        chk("drain_out_en", bus.out_en, 0);
        chk("drain_count",  count, 0);
        chk("drain_sb_empty", sb.size(), 0);

        // Reset with three pending stores discards them.
        hold_drain = 1'b1;
        force dut.pop = 1'b0;
        for (int i = 0; i < 3; i++) send(32'h8000_0100 + 32'(i) * 32'h4, 2'd2, 32'h7777_0000 + i);
        chk("pend_count", count, 3);
        ld_addr = 32'h8000_0100;
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_out_en",   bus.out_en, 0);
        chk("mid_rst_count",    count, 0);
        chk("mid_rst_in_ready", bus.in_ready, 1);
        chk("mid_rst_ld_hit",   ld_hit, 0);
        sb.delete();
        release dut.pop;
        hold_drain = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        chk("post_rst_count",  count, 0);
        chk("post_rst_out_en", bus.out_en, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
